// File: rtl/demux4_16b_wb.sv
// Write-back demultiplexer: a small FIFO of {bcast, sel, data} items whose head is routed to one of four ports.
// Optional broadcast delivery to all four ports is enabled by defining DEMUX_BROADCAST_EN.
module demux4_16b_wb #(
   parameter int DEPTH = 2,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [15:0]   in_data,
   input  logic [1:0]    in_sel,
   input  logic          in_bcast,
   output logic [15:0]   out_data,
   output logic [3:0]    out_valid,
   input  logic [3:0]    out_ready,
   output logic [AW:0]   level
);

   typedef enum logic {S_EMPTY, S_PRESENT} state_e;

   state_e        state_q;
   logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_next;
   logic [AW:0]   level_q, level_d;
   logic [3:0]    pending_q, pend_left;
   logic [15:0]   out_data_q;

   logic [15:0]   mem_data [DEPTH];
   logic [1:0]    mem_sel  [DEPTH];

   logic          push, retire, head_load;
   logic [15:0]   nxt_data;
   logic [1:0]    nxt_sel;
   logic          nxt_bcast, bcast_in, head_bcast;

`ifdef DEMUX_BROADCAST_EN
   logic          mem_bcast [DEPTH];
   assign bcast_in   = in_bcast;
   assign head_bcast = mem_bcast[rd_next];
`else
   logic          unused_bcast;
   assign unused_bcast = in_bcast;
   assign bcast_in     = 1'b0;
   assign head_bcast   = 1'b0;
`endif

   function automatic logic [3:0] load_mask(input logic [1:0] sel, input logic bcast);
      logic [3:0] m;
      m = 4'b0001 << sel;
      if (bcast) m = 4'b1111;
      return m;
   endfunction

   // in_ready depends only on registered occupancy, never on out_ready.
   assign in_ready  = !reset && (level_q < (AW+1)'(DEPTH));
   assign push      = in_valid && in_ready;
   assign pend_left = pending_q & ~out_ready;
   assign retire    = (state_q == S_PRESENT) && (pend_left == 4'b0000);
   assign rd_next   = rd_ptr_q + AW'(1);
   assign level_d   = level_q + (AW+1)'(push) - (AW+1)'(retire);

   // NOTE: every variable gets a default before any branch, so no latch is inferred.
   always_comb begin
      head_load = 1'b0;
      nxt_data  = in_data;
      nxt_sel   = in_sel;
      nxt_bcast = bcast_in;
      if (state_q == S_EMPTY) begin
         head_load = push;
      end else if (retire) begin
         if (level_q > (AW+1)'(1)) begin
            head_load = 1'b1;
            nxt_data  = mem_data[rd_next];
            nxt_sel   = mem_sel[rd_next];
            nxt_bcast = head_bcast;
         end else begin
            // Last stored item leaves; a same-edge push bypasses straight to the head.
            head_load = push;
         end
      end
   end

   // NOTE: storage has no reset; the pointers and level alone decide which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_data[wr_ptr_q] <= in_data;
         mem_sel[wr_ptr_q]  <= in_sel;
`ifdef DEMUX_BROADCAST_EN
         mem_bcast[wr_ptr_q] <= in_bcast;
`endif
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_EMPTY;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         pending_q  <= 4'b0000;
         out_data_q <= 16'h0000;
      end else begin
         if (push)   wr_ptr_q <= wr_ptr_q + AW'(1);
         if (retire) rd_ptr_q <= rd_next;
         level_q <= level_d;
         if (head_load) begin
            state_q    <= S_PRESENT;
            out_data_q <= nxt_data;
            pending_q  <= load_mask(nxt_sel, nxt_bcast);
         end else if (retire) begin
            state_q    <= S_EMPTY;
            out_data_q <= 16'h0000;
            pending_q  <= 4'b0000;
         end else begin
            pending_q  <= pend_left;
         end
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = pending_q;
   assign level     = level_q;

endmodule

// File: tb/tb_demux4_16b_wb.sv
// Self-checking bench for demux4_16b_wb: directed plan steps plus randomized traffic against a queue model.
module tb_demux4_16b_wb;
  localparam int DEPTH = 2;
  localparam int AW    = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready, in_bcast;
  logic [15:0]   in_data, out_data;
  logic [1:0]    in_sel;
  logic [3:0]    out_valid, out_ready;
  logic [AW:0]   level;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  sel;
    logic        bcast;
  } item_t;

  item_t      q[$];
  logic [3:0] rem;

  demux4_16b_wb #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sel(in_sel), .in_bcast(in_bcast),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Ports that must see an item: all four for an honoured broadcast, else the selected one.
  function automatic logic [3:0] want_mask(input item_t it);
`ifdef DEMUX_BROADCAST_EN
    if (it.bcast) return 4'b1111;
`endif
    case (it.sel)
      2'd0: return 4'b0001;
      2'd1: return 4'b0010;
      2'd2: return 4'b0100;
      default: return 4'b1000;
    endcase
  endfunction

  task automatic model_reset();
    q.delete();
    rem = 4'b0000;
  endtask

  task automatic model_edge();
    bit    accept, had_head, popped;
    item_t it;
    accept   = in_valid && !reset && (q.size() < DEPTH);
    had_head = (q.size() > 0);
    popped   = 1'b0;
    if (had_head) begin
      rem = rem & ~out_ready;
      if (rem == 4'b0000) begin
        void'(q.pop_front());
        popped = 1'b1;
      end
    end
    if (accept) begin
      it.data  = in_data;
      it.sel   = in_sel;
      it.bcast = in_bcast;
      q.push_back(it);
    end
    if (q.size() > 0 && (!had_head || popped)) rem = want_mask(q[0]);
    if (q.size() == 0) rem = 4'b0000;
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".level"},     32'(level),     32'(q.size()));
    check({tag, ".in_ready"},  32'(in_ready),  32'(!reset && q.size() < DEPTH));
    check({tag, ".out_valid"}, 32'(out_valid), (q.size() > 0) ? 32'(rem) : 32'd0);
    check({tag, ".out_data"},  32'(out_data),  (q.size() > 0) ? 32'(q[0].data) : 32'd0);
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare_model(tag);
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic [1:0] s,
                       input logic b, input logic [3:0] r);
    in_valid  = v;
    in_data   = d;
    in_sel    = s;
    in_bcast  = b;
    out_ready = r;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 16'h0, 2'd0, 1'b0, 4'b0000);
    model_reset();
    #1;
    compare_model("por");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    compare_model("release");

    // 1: reset mid-cycle with two items queued
    drive(1'b1, 16'h1111, 2'd0, 1'b0, 4'b0000);
    cycle("t1_push0");
    drive(1'b1, 16'h2222, 2'd1, 1'b0, 4'b0000);
    cycle("t1_push1");
    check("t1_level2", 32'(level), 32'd2);
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check("t1_rst_level", 32'(level), 32'd0);
    check("t1_rst_valid", 32'(out_valid), 32'd0);
    check("t1_rst_data", 32'(out_data), 32'd0);
    check("t1_rst_ready", 32'(in_ready), 32'd0);
    drive(1'b0, 16'h0, 2'd0, 1'b0, 4'b1111);
    cycle("t1_hold");
    reset = 1'b0;
    #1;
    check("t1_rel_ready", 32'(in_ready), 32'd1);
    cycle("t1_idle");
    check("t1_idle_valid", 32'(out_valid), 32'd0);

    // 2: routing, one item per cycle
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'(i + 1), 2'(i), 1'b0, 4'b1111);
      cycle("t2_route");
      check("t2_valid", 32'(out_valid), 32'(4'b0001 << i));
      check("t2_data", 32'(out_data), 32'(i + 1));
    end
    drive(1'b0, 16'h0, 2'd0, 1'b0, 4'b1111);
    cycle("t2_drain");
    check("t2_empty", 32'(out_valid), 32'd0);

    // 3: stall until full, third push refused, then single retire
    drive(1'b1, 16'hAAAA, 2'd2, 1'b0, 4'b0000);
    cycle("t3_a");
    drive(1'b1, 16'hBBBB, 2'd1, 1'b0, 4'b0000);
    cycle("t3_b");
    check("t3_full_level", 32'(level), 32'd2);
    check("t3_full_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 16'hCCCC, 2'd0, 1'b0, 4'b0000);
    cycle("t3_c");
    check("t3_c_refused", 32'(level), 32'd2);
    drive(1'b0, 16'h0, 2'd0, 1'b0, 4'b0100);
    cycle("t3_retire");
    check("t3_next_valid", 32'(out_valid), 32'b0010);
    check("t3_next_data", 32'(out_data), 32'hBBBB);
    check("t3_next_ready", 32'(in_ready), 32'd1);
    drive(1'b0, 16'h0, 2'd0, 1'b0, 4'b0010);
    cycle("t3_drain");

    // 4: ready only on unselected ports
    drive(1'b1, 16'h4444, 2'd3, 1'b0, 4'b0000);
    cycle("t4_push");
    drive(1'b0, 16'h0, 2'd0, 1'b0, 4'b0111);
    repeat (5) begin
      cycle("t4_wrong");
      check("t4_held_valid", 32'(out_valid), 32'b1000);
      check("t4_held_data", 32'(out_data), 32'h4444);
      check("t4_held_level", 32'(level), 32'd1);
    end
    drive(1'b0, 16'h0, 2'd0, 1'b0, 4'b1000);
    cycle("t4_retire");
    check("t4_gone", 32'(level), 32'd0);

    // 5: simultaneous push and retire across pointer wrap
    drive(1'b1, 16'h1000, 2'd0, 1'b0, 4'b0000);
    cycle("t5_seed");
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 16'h1234 + 16'(i), 2'(i), 1'b0, 4'b1111);
      cycle("t5_swap");
      check("t5_level", 32'(level), 32'd1);
      check("t5_data", 32'(out_data), 32'h1234 + 32'(i));
    end
    drive(1'b0, 16'h0, 2'd0, 1'b0, 4'b1111);
    cycle("t5_drain");

    // 6: broadcast (or its suppression in the default build)
    drive(1'b1, 16'h5A5A, 2'd1, 1'b1, 4'b0000);
    cycle("t6_push");
`ifdef DEMUX_BROADCAST_EN
    check("t6_all", 32'(out_valid), 32'b1111);
    drive(1'b0, 16'h0, 2'd0, 1'b0, 4'b0100);
    cycle("t6_p2");
    check("t6_after2", 32'(out_valid), 32'b1011);
    drive(1'b0, 16'h0, 2'd0, 1'b0, 4'b0001);
    cycle("t6_p0");
    check("t6_after0", 32'(out_valid), 32'b1010);
    check("t6_not_retired", 32'(level), 32'd1);
    drive(1'b0, 16'h0, 2'd0, 1'b0, 4'b1000);
    cycle("t6_p3");
    check("t6_after3", 32'(out_valid), 32'b0010);
    check("t6_hold_data", 32'(out_data), 32'h5A5A);
    drive(1'b0, 16'h0, 2'd0, 1'b0, 4'b0010);
    cycle("t6_p1");
    check("t6_after1", 32'(out_valid), 32'b0000);
    check("t6_retired", 32'(level), 32'd0);
`else
    check("t6_ignored", 32'(out_valid), 32'b0010);
    drive(1'b0, 16'h0, 2'd0, 1'b0, 4'b0010);
    cycle("t6_drain");
`endif

    // Randomized traffic with occasional asynchronous resets
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        reset = 1'b1;
        #1;
        model_reset();
        compare_model("rand_rst");
        cycle("rand_rst_hold");
        reset = 1'b0;
      end else begin
        drive(($urandom_range(0, 3) != 0), 16'($urandom), 2'($urandom),
              1'($urandom), 4'($urandom));
        cycle("rand");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
